// File: rtl/phy_tx.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx
// Brief    : Transmit framer from AXI4-Stream to 32-bit 8b/10b words.
//            Optional clock correction when PHY_TX_CC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module phy_tx #(
  parameter int P_GAP       = 2,
  parameter int P_CC_PERIOD = 5000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_link_up,
  input  logic        i_axi_s_valid,
  input  logic        i_axi_s_last,
  input  logic [3:0]  i_axi_s_keep,
  input  logic [31:0] i_axi_s_data,
  output logic        o_axi_s_ready,
  output logic [31:0] o_gt_tx_data,
  output logic [3:0]  o_gt_tx_charisk,
  output logic        o_underrun
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_data = 2'd1;
  localparam logic [1:0] c_st_eof  = 2'd2;
  localparam logic [1:0] c_st_gap  = 2'd3;

  localparam logic [31:0] c_idle_word = 32'h50BC50BC;
  localparam logic [3:0]  c_idle_k    = 4'b0101;
  localparam logic [31:0] c_sof_word  = 32'hFB50BC50;
  localparam logic [3:0]  c_sof_k     = 4'b1010;
  localparam logic [31:0] c_eof_word  = 32'h000000FD;
  localparam logic [3:0]  c_eof_k     = 4'b0001;
  localparam logic [31:0] c_cc_word   = 32'h1C1C1C1C;
  localparam logic [3:0]  c_cc_k      = 4'b1111;
  localparam logic [7:0]  c_k_fd      = 8'hFD;
  localparam int          c_gap_w     = $clog2(P_GAP + 1);

  if (P_GAP < 1 || P_CC_PERIOD < 2) begin : g_param_check
    $error("phy_tx: P_GAP must be >= 1 and P_CC_PERIOD must be >= 2");
  end

  logic [1:0]         r_state;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               r_ready;
  logic [31:0]        r_data;
  logic [3:0]         r_k;
  logic               r_underrun;
  logic               w_cc_pend;

  // Last-beat word: FD follows the final valid byte; full beats need a separate EOF word.
  logic [31:0] w_swap;
  logic [31:0] w_last_data;
  logic [3:0]  w_last_k;
  logic        w_full;

  always_comb begin
    w_swap      = {i_axi_s_data[7:0], i_axi_s_data[15:8],
                   i_axi_s_data[23:16], i_axi_s_data[31:24]};
    w_last_data = w_swap;
    w_last_k    = 4'b0000;
    w_full      = 1'b0;
    case (i_axi_s_keep)
      4'b1110: begin
        w_last_data = {c_k_fd, w_swap[23:0]};
        w_last_k    = 4'b1000;
      end
      4'b1100: begin
        w_last_data = {8'h00, c_k_fd, w_swap[15:0]};
        w_last_k    = 4'b0100;
      end
      4'b1000: begin
        w_last_data = {16'h0000, c_k_fd, w_swap[7:0]};
        w_last_k    = 4'b0010;
      end
      default: w_full = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= c_st_idle;
      r_gap_cnt  <= '0;
      r_ready    <= 1'b0;
      r_data     <= c_idle_word;
      r_k        <= c_idle_k;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_data     <= c_idle_word;
      r_k        <= c_idle_k;
      if (!i_link_up) begin
        r_state <= c_st_idle;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (w_cc_pend) begin
              r_data <= c_cc_word;
              r_k    <= c_cc_k;
            end else if (i_axi_s_valid) begin
              r_data  <= c_sof_word;
              r_k     <= c_sof_k;
              r_ready <= 1'b1;
              r_state <= c_st_data;
            end
          end
          c_st_data: begin
            if (i_axi_s_valid && r_ready) begin
              if (i_axi_s_last) begin
                r_data    <= w_last_data;
                r_k       <= w_last_k;
                r_ready   <= 1'b0;
                r_gap_cnt <= c_gap_w'(P_GAP);
                r_state   <= w_full ? c_st_eof : c_st_gap;
              end else begin
                r_data <= w_swap;
                r_k    <= 4'b0000;
              end
            end else begin
              r_underrun <= 1'b1;
            end
          end
          c_st_eof: begin
            r_data  <= c_eof_word;
            r_k     <= c_eof_k;
            r_state <= c_st_gap;
          end
          c_st_gap: begin
            if (w_cc_pend) begin
              r_data <= c_cc_word;
              r_k    <= c_cc_k;
            end
            r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
            if (r_gap_cnt <= c_gap_w'(1)) begin
              r_state <= c_st_idle;
            end
          end
          default: r_state <= c_st_idle;
        endcase
      end
    end
  end

`ifdef PHY_TX_CC_EN
  localparam int c_cc_w = $clog2(P_CC_PERIOD);

  logic [c_cc_w-1:0] r_cc_cnt;
  logic              r_cc_pend;
  logic              w_cc_wrap;
  logic              w_cc_take;

  assign w_cc_wrap = (r_cc_cnt == c_cc_w'(P_CC_PERIOD - 1));
  assign w_cc_take = i_link_up && r_cc_pend &&
                     (r_state == c_st_idle || r_state == c_st_gap);

  // A new request landing on the emission edge wins over the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cc_cnt  <= '0;
      r_cc_pend <= 1'b0;
    end else begin
      r_cc_cnt <= w_cc_wrap ? '0 : r_cc_cnt + c_cc_w'(1);
      if (w_cc_wrap) begin
        r_cc_pend <= 1'b1;
      end else if (w_cc_take) begin
        r_cc_pend <= 1'b0;
      end
    end
  end

  assign w_cc_pend = r_cc_pend;
`else
  assign w_cc_pend = 1'b0;
`endif

  assign o_axi_s_ready   = r_ready;
  assign o_gt_tx_data    = r_data;
  assign o_gt_tx_charisk = r_k;
  assign o_underrun      = r_underrun;

endmodule
`default_nettype wire
